spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have the port `clock`, input, width 1: single system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, width 1: asynchronous, active-high reset.
REQ-003 The block SHALL have the port `req_valid`, input, width 1: transfer request.
REQ-004 The block SHALL have the port `req_ready`, output, width 1: request accepted when `req_valid` and `req_ready` are both high on a `clock` edge.
REQ-005 The block SHALL have the port `tx_data`, input, width 16: bits to send, left-aligned (bit 15 is the first bit sent).
REQ-006 The block SHALL have the port `len`, input, width 5: bit count N, legal range 1..16; 0 is treated as 16.
REQ-007 The block SHALL have the port `div`, input, width 8: half-period H = div+1 `clock` cycles.
REQ-008 The block SHALL have the port `rsp_valid`, output, width 1: one-cycle pulse at transfer completion.
REQ-009 The block SHALL have the port `rx_data`, output, width 16: received bits, right-aligned (last bit received in bit 0), upper bits 0.
REQ-010 The block SHALL have the port `sck`, output, width 1: SPI clock, mode 0, idle low.
REQ-011 The block SHALL have the port `ss`, output, width 1: slave select, active low.
REQ-012 The block SHALL have the port `mosi`, output, width 1: serial data out, idle 1.
REQ-013 The block SHALL have the port `miso`, input, width 1: serial data in.

Function
REQ-014 The block SHALL implement the states IDLE, SETUP, HIGH, LOW, HOLD and GAP.
REQ-015 `req_ready` SHALL be high only in IDLE; on acceptance the block SHALL latch `tx_data`, `len` and `div` and enter SETUP, and later changes to these inputs SHALL be ignored.
REQ-016 In SETUP (H cycles), `ss` SHALL be 0, `sck` SHALL be 0 and `mosi` SHALL drive the first bit; the block SHALL then enter HIGH.
REQ-017 In HIGH (H cycles), `sck` SHALL be 1; on exit, `miso` SHALL be sampled, shifted into the rx shift register and the bit counter incremented.
REQ-018 On HIGH exit, the block SHALL go to LOW with `mosi` updated to the next bit if bits remain, otherwise to HOLD.
REQ-019 In LOW (H cycles), `sck` SHALL be 0; the block SHALL then return to HIGH.
REQ-020 In HOLD (H cycles), `ss` SHALL remain 0 and `sck` SHALL remain 0; on exit, `ss` SHALL go to 1, `rx_data` SHALL be updated and `rsp_valid` SHALL pulse high for exactly one cycle.
REQ-021 In GAP (H cycles), `ss` SHALL be 1; the block SHALL then enter IDLE, so the minimum `ss`-high time is H cycles.
REQ-022 `ss` SHALL be low for exactly (2N+1)·H cycles per transfer, with N rising `sck` edges.
REQ-023 `sck`, `ss`, `mosi`, `rsp_valid`, `req_ready` and `rx_data` SHALL be registered outputs, glitch-free.
REQ-024 The half-period counter SHALL be 8 bits, count 0..div and wrap to 0; div=0 SHALL give H=1.
REQ-025 `rx_data` SHALL hold its last value until the next completion.
REQ-026 `req_valid` asserted during a transfer SHALL be ignored until IDLE is reached.

Reset
REQ-027 While `reset` is high, the block SHALL be in IDLE with `sck`=0, `ss`=1, `mosi`=1, `rsp_valid`=0, `rx_data`=0 and `req_ready`=0.
REQ-028 `req_ready` SHALL rise on the first `clock` edge after `reset` is released.
REQ-029 A reset asserted mid-transfer SHALL immediately force the IDLE output values, discard partial data and produce no `rsp_valid`.

Configuration
REQ-030 With SPI_MASTER_LSB_FIRST_EN defined, the block SHALL transmit `tx_data[0]` first, moving upward through `tx_data[N-1]`, and SHALL assemble `rx_data` with the first bit received in bit 0.
REQ-031 Without SPI_MASTER_LSB_FIRST_EN, the block SHALL operate MSB-first as in REQ-005 and REQ-009.

Verification
REQ-032 The bench SHALL cover loopback (`miso`=`mosi`), `tx_data`=0xA5C3, N=16, div=0 -> `rx_data`=0xA5C3, `ss` low for 33 cycles, and 16 `sck` rising edges.
REQ-033 The bench SHALL cover `miso` tied to 1, N=8, div=3 -> `rx_data`=0x00FF, `sck` high and low phases each 4 cycles, and `ss` low for 68 cycles.
REQ-034 The bench SHALL cover an 8-bit SPI slave echo model that returns each received byte on the next 8 clocks, with N=16 and `tx_data`=0x3C00 -> `rx_data[7:0]`=0x3C.
REQ-035 The bench SHALL cover back-to-back requests with `req_valid` held high -> `rsp_valid` pulses once per transfer and `ss` stays high for at least H cycles between transfers.
REQ-036 The bench SHALL cover `reset` pulsed after the 5th `sck` rise -> `ss`=1, `sck`=0 and `mosi`=1 immediately, no `rsp_valid`, and the next transfer is correct.
REQ-037 The bench SHALL cover `len`=0 -> 16 bits transferred, and `len`=1 -> a single `sck` pulse with `rx_data`=`miso` in bit 0.

Source files
------------

// File: rtl/spi_master.sv
// Mode-0 SPI master: 1..16 bit transfers, half-period of (div+1) clocks.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting; default is MSB-first.
module spi_master (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] tx_data,
  input  logic [4:0]  len,
  input  logic [7:0]  div,
  output logic        rsp_valid,
  output logic [15:0] rx_data,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t state, state_next;

  logic [15:0] tx_shift;
  logic [15:0] rx_shift;
  logic [4:0]  len_r;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_r;
  logic [7:0]  hcnt;
  logic        accept;
  logic        phase_done;
  logic        last_bit;

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign phase_done = (hcnt == div_r);
  assign last_bit   = ((bit_cnt + 5'd1) == len_r);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = SETUP;
      SETUP:   if (phase_done) state_next = HIGH;
      HIGH:    if (phase_done) state_next = last_bit ? HOLD : LOW;
      LOW:     if (phase_done) state_next = HIGH;
      HOLD:    if (phase_done) state_next = GAP;
      GAP:     if (phase_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin outputs are registered from state_next so they align with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      len_r     <= '0;
      div_r     <= '0;
      hcnt      <= '0;
      bit_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rx_data   <= '0;
      sck       <= 1'b0;
      ss        <= 1'b1;
      mosi      <= 1'b1;
    end else begin
      req_ready <= (state_next == IDLE);
      sck       <= (state_next == HIGH);
      ss        <= (state_next == IDLE) || (state_next == GAP);
      rsp_valid <= (state == HOLD) && phase_done;

      if (state == IDLE || phase_done) begin
        hcnt <= '0;
      end else begin
        hcnt <= hcnt + 8'd1;
      end

      if (accept) begin
        len_r    <= (len == 5'd0) ? 5'd16 : len;
        div_r    <= div;
        bit_cnt  <= '0;
        rx_shift <= '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
        mosi     <= tx_data[0];
        tx_shift <= {1'b0, tx_data[15:1]};
`else
        mosi     <= tx_data[15];
        tx_shift <= {tx_data[14:0], 1'b0};
`endif
      end

      if (state == HIGH && phase_done) begin
        bit_cnt <= bit_cnt + 5'd1;
`ifdef SPI_MASTER_LSB_FIRST_EN
        rx_shift[bit_cnt[3:0]] <= miso;
`else
        rx_shift <= {rx_shift[14:0], miso};
`endif
        if (!last_bit) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
          mosi     <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[15:1]};
`else
          mosi     <= tx_shift[15];
          tx_shift <= {tx_shift[14:0], 1'b0};
`endif
        end
      end

      if (state == HOLD && phase_done) begin
        rx_data <= rx_shift;
        mosi    <= 1'b1;
      end
    end
  end

endmodule
